pipe_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage CPU. Each cycle it computes the write enables and clear controls for the PC, IF/ID and ID/EX pipeline registers (all `write_en`-gated 32-bit flops). It resolves four hazard sources under a fixed priority: data-memory wait, taken-branch flush, fixed-latency multiply/divide occupancy, and load-use. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stall_ctrl_if.sv | 37 +++
 rtl/pipe_stall_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the
// pipeline datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_is_md;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_wait;

    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_bubble;
    logic        md_go;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
        output ex_is_load, ex_rd, ex_branch_taken, mem_wait,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
        input  md_go, md_busy, md_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
        input  ex_is_load, ex_rd, ex_branch_taken, mem_wait,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
        output md_go, md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: resolves memory wait,
// taken-branch flush, mul/div occupancy and load-use under fixed priority,
// and counts stalled cycles (saturating) for performance debug.
module pipe_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CW         = 6
) (
    input logic              clk,
    input logic              clrn,
    pipe_stall_ctrl_if.slave bus
);

    // Counter preload so that MD_WAIT lasts exactly MD_LATENCY cycles.
    localparam logic [CW-1:0] MdInit = CW'(MD_LATENCY - 1);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;

    logic lu;
    logic md_zero;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_go, md_busy, md_done;

    assign md_zero = (md_cnt_q == '0);

    // Load-use: EX load writes a register that the ID instruction actually reads.
    assign lu = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

    // State register: FSM state, mul/div down-counter and stall counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= StRun;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state: mul/div occupancy counts down regardless of mem_wait.
    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            StRun: begin
                if (md_go) begin
                    state_d  = StMdWait;
                    md_cnt_d = MdInit;
                end
            end
            StMdWait: begin
                if (md_zero) begin
                    state_d = StRun;
                end else begin
                    md_cnt_d = md_cnt_q - CW'(1);
                end
            end
            default: state_d = StRun;
        endcase
        if (!pc_we && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Output decode in priority order; everything held low during reset.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_bubble = 1'b0;
        md_go       = 1'b0;
        if (clrn) begin
            if (bus.mem_wait) begin
                // Whole pipeline holds; all controls stay low.
            end else if ((state_q == StRun) && bus.ex_branch_taken) begin
                // Wrong-path fetch and ID instruction (including a mul/div) squashed.
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                idex_we     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (state_q == StMdWait) begin
                idex_we     = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                idex_we     = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                idex_we = 1'b1;
                md_go   = bus.id_is_md;
            end
        end
        md_busy = clrn && (state_q == StMdWait);
        md_done = md_busy && md_zero;
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.idex_bubble = idex_bubble;
    assign bus.md_go       = md_go;
    assign bus.md_busy     = md_busy;
    assign bus.md_done     = md_done;
    assign bus.stall_cnt   = clrn ? stall_cnt_q : 32'd0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a combinational decode table in RUN plus
// hand-written multi-cycle sequences (load-use, mul/div, mem_wait, saturation, reset).
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if if_a ();
    pipe_stall_ctrl_if if_b ();

    pipe_stall_ctrl #(.MD_LATENCY(4), .CW(6)) dut_a (
        .clk  (clk),
        .clrn (clrn),
        .bus  (if_a)
    );

    pipe_stall_ctrl #(.MD_LATENCY(32), .CW(6)) dut_b (
        .clk  (clk),
        .clrn (clrn),
        .bus  (if_b)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_stall = 32'd0;
    logic        exp_pc    = 1'b1;

    // Expected controls packed as {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_go}.
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       md;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       mw;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                           input logic urt, input logic md, input logic ld,
                           input logic [4:0] rd, input logic br, input logic mw);
        if_a.id_rs           = rs;
        if_a.id_rt           = rt;
        if_a.id_use_rs       = urs;
        if_a.id_use_rt       = urt;
        if_a.id_is_md        = md;
        if_a.ex_is_load      = ld;
        if_a.ex_rd           = rd;
        if_a.ex_branch_taken = br;
        if_a.mem_wait        = mw;
    endtask

    task automatic idle_a();
        drive_a(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check({tag, ".pc_we"},       32'(if_a.pc_we),       32'(exp[5]));
        check({tag, ".ifid_we"},     32'(if_a.ifid_we),     32'(exp[4]));
        check({tag, ".ifid_flush"},  32'(if_a.ifid_flush),  32'(exp[3]));
        check({tag, ".idex_we"},     32'(if_a.idex_we),     32'(exp[2]));
        check({tag, ".idex_bubble"}, 32'(if_a.idex_bubble), 32'(exp[1]));
        check({tag, ".md_go"},       32'(if_a.md_go),       32'(exp[0]));
        check({tag, ".stall_cnt"},   if_a.stall_cnt,        exp_stall);
        exp_pc = exp[5];
    endtask

    task automatic check_md(input string tag, input logic busy, input logic done);
        check({tag, ".md_busy"}, 32'(if_a.md_busy), 32'(busy));
        check({tag, ".md_done"}, 32'(if_a.md_done), 32'(done));
    endtask

    // One clock: update the stall model at the posedge, return at the next negedge.
    task automatic advance();
        @(posedge clk);
        if (!clrn) exp_stall = 32'd0;
        else if (!exp_pc && (exp_stall != 32'hFFFF_FFFF)) exp_stall = exp_stall + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] base;
        logic [5:0]  e;

        //           rs     rt     urs   urt   md    ld    rd     br    mw    expected
        vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 6'b110100};
        vecs[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 6'b000110};
        vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 6'b110100};
        vecs[3]  = '{5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 6'b110100};
        vecs[4]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 6'b000110};
        vecs[5]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 6'b110100};
        vecs[6]  = '{5'd5,  5'd3,  1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 6'b110100};
        vecs[7]  = '{5'd31, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 6'b000110};
        vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 6'b000000};
        vecs[9]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 6'b000000};
        vecs[10] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 6'b111110};
        vecs[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 6'b111110};
        vecs[12] = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 6'b000110};
        vecs[13] = '{5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 6'b110100};

        if_b.id_rs = 5'd0; if_b.id_rt = 5'd0; if_b.id_use_rs = 1'b0; if_b.id_use_rt = 1'b0;
        if_b.id_is_md = 1'b0; if_b.ex_is_load = 1'b0; if_b.ex_rd = 5'd0;
        if_b.ex_branch_taken = 1'b0; if_b.mem_wait = 1'b0;

        // Reset held: even a branch + mul/div request must produce all-zero controls.
        drive_a(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        check_ctl("reset", 6'b000000);
        check_md("reset", 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        exp_stall = 32'd0;

        // Combinational decode table in RUN (no vector raises md_go).
        for (int i = 0; i < 14; i++) begin
            drive_a(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].md,
                    vecs[i].ld, vecs[i].rd, vecs[i].br, vecs[i].mw);
            #1;
            check_ctl($sformatf("vec%0d", i), vecs[i].exp);
            check_md($sformatf("vec%0d", i), 1'b0, 1'b0);
            advance();
        end

        // Load-use stalls exactly one cycle; next cycle the load has left EX.
        drive_a(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        check_ctl("lu_c0", 6'b000110);
        advance();
        drive_a(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        #1;
        check_ctl("lu_c1", 6'b110100);
        advance();

        // Mul/div issue with latency 4; a branch in MD_WAIT must be ignored.
        base = exp_stall;
        drive_a(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check_ctl("md_t0", 6'b110101);
        check_md("md_t0", 1'b0, 1'b0);
        advance();
        for (int k = 1; k <= 4; k++) begin
            idle_a();
            if (k == 2) if_a.ex_branch_taken = 1'b1;
            #1;
            check_ctl($sformatf("md_t%0d", k), 6'b000110);
            check_md($sformatf("md_t%0d", k), 1'b1, k == 4);
            advance();
        end
        idle_a();
        #1;
        check_ctl("md_t5", 6'b110100);
        check_md("md_t5", 1'b0, 1'b0);
        check("md_stall_delta", if_a.stall_cnt, base + 32'd4);
        advance();

        // Mul/div with mem_wait over T+2..T+6: counter keeps running under the wait.
        base = exp_stall;
        drive_a(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check_ctl("mw_t0", 6'b110101);
        advance();
        for (int k = 1; k <= 7; k++) begin
            idle_a();
            if_a.mem_wait = (k >= 2) && (k <= 6);
            e = (k == 1) ? 6'b000110 : ((k <= 6) ? 6'b000000 : 6'b110100);
            #1;
            check_ctl($sformatf("mw_t%0d", k), e);
            check_md($sformatf("mw_t%0d", k), k <= 4, k == 4);
            advance();
        end
        check("mw_stall_delta", if_a.stall_cnt, base + 32'd6);

        // Saturation: preload the counter to 0xFFFFFFFE, then three stall cycles.
        idle_a();
        force dut_a.stall_cnt_q = 32'hFFFF_FFFE;
        exp_stall = 32'hFFFF_FFFE;
        #1;
        check_ctl("sat_load", 6'b110100);
        advance();
        release dut_a.stall_cnt_q;
        for (int k = 0; k < 3; k++) begin
            idle_a();
            if_a.mem_wait = 1'b1;
            #1;
            check_ctl($sformatf("sat%0d", k), 6'b000000);
            advance();
        end
        idle_a();
        #1;
        check_ctl("sat_end", 6'b110100);
        check("sat_hold", if_a.stall_cnt, 32'hFFFF_FFFF);

        // Reset in the middle of MD_WAIT on the latency-32 instance (md_cnt = 10).
        if_b.id_is_md = 1'b1;
        advance();
        if_b.id_is_md = 1'b0;
        repeat (21) advance();
        check("rst_pre_busy", 32'(if_b.md_busy), 32'd1);
        check("rst_pre_done", 32'(if_b.md_done), 32'd0);
        check("rst_pre_stall", if_b.stall_cnt, 32'd21);
        #2;
        clrn = 1'b0;
        exp_stall = 32'd0;
        #1;
        check("rst_b_pc_we", 32'(if_b.pc_we), 32'd0);
        check("rst_b_ifid_we", 32'(if_b.ifid_we), 32'd0);
        check("rst_b_idex_we", 32'(if_b.idex_we), 32'd0);
        check("rst_b_bubble", 32'(if_b.idex_bubble), 32'd0);
        check("rst_b_busy", 32'(if_b.md_busy), 32'd0);
        check("rst_b_stall", if_b.stall_cnt, 32'd0);
        check_ctl("rst_a", 6'b000000);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check("rel_b_pc_we", 32'(if_b.pc_we), 32'd1);
        check("rel_b_busy", 32'(if_b.md_busy), 32'd0);
        check("rel_b_stall", if_b.stall_cnt, 32'd0);
        check_ctl("rel_a", 6'b110100);
        advance();
        #1;
        check("rel_b_busy2", 32'(if_b.md_busy), 32'd0);
        check("rel_b_stall2", if_b.stall_cnt, 32'd0);
        check_ctl("rel_a2", 6'b110100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
